// File: rtl/rv32_regfile_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32_regfile_wb_if
// Description : Bundle of the register-file signals: write-back port, two
//               read ports, issue/flush scoreboard controls and status.
//               master = pipeline side (drives indices/data/controls)
//               slave  = register file (drives read data, busy, pending)
// Ports (signals):
//   reg_write_en, rd, wb_data       write-back port
//   rs1_addr, rs2_addr              read indices
//   rs1_data, rs2_data              read data (combinational)
//   issue_en, issue_rd, flush       scoreboard controls
//   rs1_busy, rs2_busy, pending     scoreboard status
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32_regfile_wb_if #(
  parameter int XLEN = 32
);
  logic            reg_write_en;
  logic [4:0]      rd;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            issue_en;
  logic [4:0]      issue_rd;
  logic            flush;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [31:0]     pending;

  modport master (
    output reg_write_en, rd, wb_data, rs1_addr, rs2_addr,
           issue_en, issue_rd, flush,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, pending
  );

  modport slave (
    input  reg_write_en, rd, wb_data, rs1_addr, rs2_addr,
           issue_en, issue_rd, flush,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, pending
  );
endinterface
`default_nettype wire

// File: rtl/rv32_regfile_wb.sv
`default_nettype none
// ============================================================================
// Module      : rv32_regfile_wb
// Description : 32 x XLEN integer register file with two combinational read
//               ports, optional same-cycle write-to-read bypass, and a
//               per-register pending-write scoreboard (set at issue, cleared
//               at write-back, wiped by flush).
// Ports       :
//   clk    - core clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - rv32_regfile_wb_if.slave (write-back, read, scoreboard signals)
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_regfile_wb #(
  parameter int XLEN      = 32,
  parameter int BYPASS_EN = 1
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  rv32_regfile_wb_if.slave  bus
);

  localparam int c_NREGS = 32;

  // Entry 0 is reset to zero and never written, so it reads back 0 even if
  // the explicit x0 guard below were ever bypassed.
  logic [XLEN-1:0] r_regs [c_NREGS];
  logic [31:0]     r_pending;
  logic [31:0]     w_pending_nxt;

  logic            w_wr_valid;
  logic            w_hit1;
  logic            w_hit2;

  assign w_wr_valid = bus.reg_write_en && (bus.rd != 5'd0);

  // --------------------------------------------------------------------------
  // Register array
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_valid) begin
      r_regs[bus.rd] <= bus.wb_data;
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard next state. The clear from write-back is applied first so a
  // same-cycle issue to the same register (a newer producer) overrides it;
  // flush overrides both.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pending_nxt = r_pending;
    if (bus.flush) begin
      w_pending_nxt = '0;
    end else begin
      if (w_wr_valid) begin
        w_pending_nxt[bus.rd] = 1'b0;
      end
      if (bus.issue_en && (bus.issue_rd != 5'd0)) begin
        w_pending_nxt[bus.issue_rd] = 1'b1;
      end
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign bus.pending = r_pending;

  // --------------------------------------------------------------------------
  // Read ports. A bypass hit forwards wb_data and also hides the busy bit,
  // since the consumer receives the producer's result this very cycle.
  // Outputs are forced to 0 while reset is held so an in-flight write cannot
  // leak through the bypass path.
  // --------------------------------------------------------------------------
  assign w_hit1 = (BYPASS_EN != 0) && bus.reg_write_en && (bus.rd == bus.rs1_addr);
  assign w_hit2 = (BYPASS_EN != 0) && bus.reg_write_en && (bus.rd == bus.rs2_addr);

  always_comb begin
    bus.rs1_data = '0;
    bus.rs1_busy = 1'b0;
    if (rst_n && (bus.rs1_addr != 5'd0)) begin
      bus.rs1_data = w_hit1 ? bus.wb_data : r_regs[bus.rs1_addr];
      bus.rs1_busy = r_pending[bus.rs1_addr] && !w_hit1;
    end
  end

  always_comb begin
    bus.rs2_data = '0;
    bus.rs2_busy = 1'b0;
    if (rst_n && (bus.rs2_addr != 5'd0)) begin
      bus.rs2_data = w_hit2 ? bus.wb_data : r_regs[bus.rs2_addr];
      bus.rs2_busy = r_pending[bus.rs2_addr] && !w_hit2;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32_regfile_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_regfile_wb
// Description : Self-checking bench for rv32_regfile_wb. Two instances (bypass
//               on and off) receive identical stimulus. The driver computes
//               expected outputs from an array/bit-vector reference model and
//               queues them; a monitor pops and compares each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_regfile_wb;

  logic clk;
  logic rst_n;

  rv32_regfile_wb_if #(.XLEN(32)) bus_b1 ();
  rv32_regfile_wb_if #(.XLEN(32)) bus_b0 ();

  rv32_regfile_wb #(.XLEN(32), .BYPASS_EN(1)) dut_b1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b1.slave)
  );

  rv32_regfile_wb #(.XLEN(32), .BYPASS_EN(0)) dut_b0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:0] d1_b1, d2_b1, d1_b0, d2_b0;
    logic        bz1_b1, bz2_b1, bz1_b0, bz2_b0;
    logic [31:0] pend;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: architectural register contents and pending set
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;

  int n_cmp;
  int n_err;
  int tag_cnt;

  function automatic logic [31:0] exp_data(input logic rst, input logic we,
      input logic [4:0] wrd, input logic [31:0] wd, input logic [4:0] a, input bit byp);
    if (!rst || a == 5'd0) return 32'd0;
    if (byp && we && wrd == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic rst, input logic we,
      input logic [4:0] wrd, input logic [4:0] a, input bit byp);
    if (!rst || a == 5'd0) return 1'b0;
    return m_pend[a] && !(byp && we && wrd == a);
  endfunction

  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step=%0d actual=0x%08h expected=0x%08h", name, tag, act, exp);
    end
  endtask

  // One cycle of stimulus: drive at negedge, queue expectations, advance model.
  task automatic step(input logic rst, input logic we, input logic [4:0] wrd,
                      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                      input logic iss, input logic [4:0] ird, input logic fl);
    exp_t e;
    @(negedge clk);
    rst_n               = rst;
    bus_b1.reg_write_en = we;   bus_b0.reg_write_en = we;
    bus_b1.rd           = wrd;  bus_b0.rd           = wrd;
    bus_b1.wb_data      = wd;   bus_b0.wb_data      = wd;
    bus_b1.rs1_addr     = a1;   bus_b0.rs1_addr     = a1;
    bus_b1.rs2_addr     = a2;   bus_b0.rs2_addr     = a2;
    bus_b1.issue_en     = iss;  bus_b0.issue_en     = iss;
    bus_b1.issue_rd     = ird;  bus_b0.issue_rd     = ird;
    bus_b1.flush        = fl;   bus_b0.flush        = fl;

    if (!rst) begin
      // asynchronous reset takes effect immediately
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_pend = 32'd0;
    end

    e.tag    = tag_cnt;
    e.d1_b1  = exp_data(rst, we, wrd, wd, a1, 1'b1);
    e.d2_b1  = exp_data(rst, we, wrd, wd, a2, 1'b1);
    e.d1_b0  = exp_data(rst, we, wrd, wd, a1, 1'b0);
    e.d2_b0  = exp_data(rst, we, wrd, wd, a2, 1'b0);
    e.bz1_b1 = exp_busy(rst, we, wrd, a1, 1'b1);
    e.bz2_b1 = exp_busy(rst, we, wrd, a2, 1'b1);
    e.bz1_b0 = exp_busy(rst, we, wrd, a1, 1'b0);
    e.bz2_b0 = exp_busy(rst, we, wrd, a2, 1'b0);
    e.pend   = rst ? m_pend : 32'd0;
    exp_q.push_back(e);
    tag_cnt++;

    // State after the coming rising edge
    if (rst) begin
      if (we && wrd != 5'd0) m_regs[wrd] = wd;
      if (fl) begin
        m_pend = 32'd0;
      end else begin
        if (we) m_pend[wrd] = 1'b0;
        if (iss && ird != 5'd0) m_pend[ird] = 1'b1;
      end
    end
  endtask

  task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
    step(1'b1, 1'b0, 5'd0, 32'd0, a1, a2, 1'b0, 5'd0, 1'b0);
  endtask

  function automatic logic [4:0] rnd_idx();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  // Monitor: compare queued expectations against both instances
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rs1_data_byp1", e.tag, bus_b1.rs1_data, e.d1_b1);
        check("rs2_data_byp1", e.tag, bus_b1.rs2_data, e.d2_b1);
        check("rs1_data_byp0", e.tag, bus_b0.rs1_data, e.d1_b0);
        check("rs2_data_byp0", e.tag, bus_b0.rs2_data, e.d2_b0);
        check("rs1_busy_byp1", e.tag, {31'd0, bus_b1.rs1_busy}, {31'd0, e.bz1_b1});
        check("rs2_busy_byp1", e.tag, {31'd0, bus_b1.rs2_busy}, {31'd0, e.bz2_b1});
        check("rs1_busy_byp0", e.tag, {31'd0, bus_b0.rs1_busy}, {31'd0, e.bz1_b0});
        check("rs2_busy_byp0", e.tag, {31'd0, bus_b0.rs2_busy}, {31'd0, e.bz2_b0});
        check("pending_byp1",  e.tag, bus_b1.pending, e.pend);
        check("pending_byp0",  e.tag, bus_b0.pending, e.pend);
      end
    end
  end

  // Driver
  initial begin
    int waited;
    n_cmp = 0; n_err = 0; tag_cnt = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pend = 32'd0;
    rst_n = 1'b0;
    bus_b1.reg_write_en = 1'b0; bus_b0.reg_write_en = 1'b0;
    bus_b1.rd = 5'd0;           bus_b0.rd = 5'd0;
    bus_b1.wb_data = 32'd0;     bus_b0.wb_data = 32'd0;
    bus_b1.rs1_addr = 5'd0;     bus_b0.rs1_addr = 5'd0;
    bus_b1.rs2_addr = 5'd0;     bus_b0.rs2_addr = 5'd0;
    bus_b1.issue_en = 1'b0;     bus_b0.issue_en = 1'b0;
    bus_b1.issue_rd = 5'd0;     bus_b0.issue_rd = 5'd0;
    bus_b1.flush = 1'b0;        bus_b0.flush = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd7, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd31, 1'b0, 5'd0, 1'b0);

    // Asynchronous reset mid-cycle, including a write held during reset
    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0);
    idle_read(5'd5, 5'd5);
    step(1'b0, 1'b1, 5'd5, 32'h0000_0001, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
    idle_read(5'd5, 5'd0);

    // Write/read and x0
    step(1'b1, 1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd7, 5'd0, 1'b1, 5'd0, 1'b0);
    idle_read(5'd7, 5'd0);

    // Same-cycle bypass
    step(1'b1, 1'b1, 5'd3, 32'h11, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 5'd3, 32'h22, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0);
    idle_read(5'd3, 5'd3);

    // Scoreboard lifecycle on x9
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0);
    idle_read(5'd9, 5'd9);
    idle_read(5'd9, 5'd9);
    idle_read(5'd9, 5'd9);
    step(1'b1, 1'b1, 5'd9, 32'h99, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0);
    idle_read(5'd9, 5'd9);

    // Issue wins over same-cycle write-back; separate write-back clears only its bit
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd12, 5'd13, 1'b1, 5'd12, 1'b0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd12, 5'd13, 1'b1, 5'd13, 1'b0);
    step(1'b1, 1'b1, 5'd12, 32'hC, 5'd12, 5'd13, 1'b1, 5'd12, 1'b0);
    step(1'b1, 1'b1, 5'd13, 32'hD, 5'd12, 5'd13, 1'b0, 5'd0, 1'b0);
    idle_read(5'd12, 5'd13);

    // Flush with pending 0x0F00 (after clearing x12), same-cycle issue and write-back
    step(1'b1, 1'b1, 5'd12, 32'hC2, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int r = 8; r < 12; r++) begin
      step(1'b1, 1'b0, 5'd0, 32'd0, 5'd8, 5'd4, 1'b1, 5'(r), 1'b0);
    end
    step(1'b1, 1'b1, 5'd8, 32'hAB, 5'd8, 5'd4, 1'b1, 5'd4, 1'b1);
    idle_read(5'd8, 5'd4);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 1) == 1),
           rnd_idx(), $urandom(), rnd_idx(), rnd_idx(),
           ($urandom_range(0, 2) == 0), rnd_idx(),
           ($urandom_range(0, 15) == 0));
    end

    // Drain the scoreboard with a bounded wait
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #4;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain leftover=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
